// File: rtl/edge_job_initiator_pkg.sv
// Shared definitions for the edge-detection job initiator.
// Holds the sequencer state encoding and the bus word-size helpers.
package edge_job_initiator_pkg;

  localparam int unsigned STATE_W = 3;

  // Sequencer states; the encoding is fixed so waveforms stay readable.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RD       = 3'd2,
    ST_PUSH     = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_WR       = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned BYTES_PER_WORD = DEFAULT_DATA_W / 8;

  // Byte-address step between consecutive bus words.
  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/edge_job_watchdog.sv
// Loadable up-counter with clear, enable and a registered expiry flag.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        force count to zero (highest priority)
//   load_i         load load_val_i
//   load_val_i     value loaded by load_i
//   en_i           count up by one (saturating)
//   limit_i        expiry threshold; 0 never expires
//   expired_o      high while the count equals limit_i
module edge_job_watchdog #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Next count and the flag that will accompany it.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = (limit_i != '0) && (count_d == limit_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/edge_job_initiator.sv
// Host-side sequencer for the edge-detection accelerator. For each job it
// pulses start, reads IN_WORDS words over Avalon-MM, streams them to the
// accelerator, waits for the result and writes it back, then advances the
// source/destination addresses until the programmed job count is exhausted.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   go_i, src_addr_i, dst_addr_i,
//   count_i                       launch request and run parameters (IDLE only)
//   busy_o, done_o, error_o       run status; error_o is a sticky watchdog flag
//   avm_*                         Avalon-MM master (shared read/write)
//   acc_*                         accelerator start / input / result handshake
// All outputs are registered and line up with the state they belong to.
module edge_job_initiator
  import edge_job_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IN_WORDS = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [DATA_W-1:0] avm_writedata_o,
  input  logic [DATA_W-1:0] avm_readdata_i,
  input  logic              avm_waitrequest_i,
  output logic              acc_start_o,
  output logic [DATA_W-1:0] acc_data_o,
  output logic              acc_data_valid_o,
  input  logic              acc_data_ready_i,
  input  logic [DATA_W-1:0] acc_result_i,
  input  logic              acc_valid_i,
  output logic              acc_result_ack_o
);

  localparam int unsigned STEP  = bytes_per_word(DATA_W);
  localparam int unsigned IDX_W = $clog2(IN_WORDS + 1);
  localparam int unsigned WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              error_q, error_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] adata_q, adata_d;
  logic              avalid_q, avalid_d;
  logic              ack_q, ack_d;

  logic              wd_clear, wd_load, wd_en, wd_expired, timeout_hit;

  // Result watchdog: loaded with 1 on WAIT_RES entry so its count equals the
  // number of WAIT_RES cycles spent; the flag rises in the TIMEOUT-th cycle.
  edge_job_watchdog #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (wd_clear),
    .load_i     (wd_load),
    .load_val_i (WD_W'(1)),
    .en_i       (wd_en),
    .limit_i    (WD_W'(TIMEOUT)),
    .expired_o  (wd_expired)
  );

  assign timeout_hit = (TIMEOUT != 0) && wd_expired;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    word_d   = word_q;
    result_d = result_q;
    error_d  = error_q;
    ack_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          src_d    = src_addr_i;
          dst_d    = dst_addr_i;
          remain_d = count_i;
          error_d  = 1'b0;
          state_d  = (count_i == '0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        idx_d   = '0;
        state_d = ST_RD;
      end
      ST_RD: begin
        if (!avm_waitrequest_i) begin
          word_d  = avm_readdata_i;
          src_d   = src_q + ADDR_W'(STEP);
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (acc_data_ready_i) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_d == IDX_W'(IN_WORDS)) ? ST_WAIT_RES : ST_RD;
        end
      end
      ST_WAIT_RES: begin
        // A result in the expiry cycle wins over the timeout.
        if (acc_valid_i) begin
          result_d = acc_result_i;
          ack_d    = 1'b1;
          state_d  = ST_WR;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        if (!avm_waitrequest_i) begin
          dst_d   = dst_q + ADDR_W'(STEP);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        remain_d = remain_q - CNT_W'(1);
        state_d  = (remain_d == '0) ? ST_DONE : ST_START;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wd_clear = (state_d != ST_WAIT_RES);
    wd_load  = (state_d == ST_WAIT_RES) && (state_q != ST_WAIT_RES);
    wd_en    = (state_d == ST_WAIT_RES) && (state_q == ST_WAIT_RES);

    // Outputs are decoded from the next state so the flops track state_q.
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    rd_d     = (state_d == ST_RD);
    wr_d     = (state_d == ST_WR);
    start_d  = (state_d == ST_START);
    avalid_d = (state_d == ST_PUSH);

    addr_d = addr_q;
    if (state_d == ST_RD) begin
      addr_d = src_d;
    end else if (state_d == ST_WR) begin
      addr_d = dst_d;
    end
    wdata_d = (state_d == ST_WR)   ? result_d : wdata_q;
    adata_d = (state_d == ST_PUSH) ? word_d   : adata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      start_q  <= 1'b0;
      adata_q  <= '0;
      avalid_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      start_q  <= start_d;
      adata_q  <= adata_d;
      avalid_q <= avalid_d;
      ack_q    <= ack_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign avm_address_o    = addr_q;
  assign avm_read_o       = rd_q;
  assign avm_write_o      = wr_q;
  assign avm_writedata_o  = wdata_q;
  assign acc_start_o      = start_q;
  assign acc_data_o       = adata_q;
  assign acc_data_valid_o = avalid_q;
  assign acc_result_ack_o = ack_q;

endmodule

// File: tb/tb_edge_job_initiator.sv
// Self-checking bench for edge_job_initiator: a memory slave and an
// accelerator model react each negedge; test tasks launch runs and compare
// the logged traffic with lists computed from the run parameters.
module tb_edge_job_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst_i, go_i;
  logic [AW-1:0] src_addr_i, dst_addr_i;
  logic [CW-1:0] count_i;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] avm_address_o;
  logic          avm_read_o, avm_write_o;
  logic [DW-1:0] avm_writedata_o, avm_readdata_i;
  logic          avm_waitrequest_i;
  logic          acc_start_o;
  logic [DW-1:0] acc_data_o, acc_result_i;
  logic          acc_data_valid_o, acc_data_ready_i, acc_valid_i, acc_result_ack_o;

  edge_job_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .IN_WORDS(NW), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .go_i(go_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_readdata_i(avm_readdata_i),
    .avm_waitrequest_i(avm_waitrequest_i),
    .acc_start_o(acc_start_o), .acc_data_o(acc_data_o), .acc_data_valid_o(acc_data_valid_o),
    .acc_data_ready_i(acc_data_ready_i), .acc_result_i(acc_result_i),
    .acc_valid_i(acc_valid_i), .acc_result_ack_o(acc_result_ack_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 40000 cycles");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Knobs written only by the test tasks.
  int          wait_pct = 0, ready_pct = 100, res_lat = 0, clear_gen = 0;
  bit          rand_lat = 0, acc_silent = 0, force_wr_wait = 0;
  logic [31:0] seed_mem = 32'h1234_5678;

  // Logs and model state written only by the model process.
  logic [31:0] rd_log[$], push_log[$], wa_log[$], wd_log[$];
  int          start_cnt, done_cnt, viol_cnt, cyc, first_start_cyc, done_cyc, last_push_cyc;
  int          seen_gen = 0, win_n, res_cd;
  logic [31:0] win [NW];
  bit          prev_rd_stall, prev_wr_stall, prev_push_stall;
  logic [31:0] prev_addr, prev_wdata, prev_adata;

  // Expected traffic, written only by build_expected.
  logic [31:0] exp_rd[$], exp_push[$], exp_wa[$], exp_wd[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed_mem;
  endfunction

  // The accelerator's function is arbitrary here; only its consistency matters.
  function automatic logic [31:0] acc_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    return (a ^ {b[15:0], b[31:16]}) + (c << 3) + 32'h5;
  endfunction

  // Memory slave, accelerator and protocol monitor, one step per negedge.
  initial begin
    avm_waitrequest_i = 1'b0;
    avm_readdata_i    = '0;
    acc_data_ready_i  = 1'b0;
    acc_valid_i       = 1'b0;
    acc_result_i      = '0;
    forever begin
      @(negedge clk);
      if (seen_gen != clear_gen) begin
        seen_gen = clear_gen;
        rd_log.delete(); push_log.delete(); wa_log.delete(); wd_log.delete();
        start_cnt = 0; done_cnt = 0; viol_cnt = 0; cyc = 0;
        first_start_cyc = -1; done_cyc = -1; last_push_cyc = -1;
        win_n = 0; res_cd = 0; acc_valid_i = 1'b0;
        prev_rd_stall = 0; prev_wr_stall = 0; prev_push_stall = 0;
      end
      cyc++;
      if (prev_rd_stall && (!avm_read_o || avm_address_o !== prev_addr)) viol_cnt++;
      if (prev_wr_stall && (!avm_write_o || avm_address_o !== prev_addr ||
                            avm_writedata_o !== prev_wdata)) viol_cnt++;
      if (prev_push_stall && (!acc_data_valid_o || acc_data_o !== prev_adata)) viol_cnt++;
      if (avm_read_o && avm_write_o) viol_cnt++;
      if (acc_start_o) begin
        start_cnt++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (acc_result_ack_o) acc_valid_i = 1'b0;
      if (res_cd > 0) begin
        res_cd--;
        if (res_cd == 0) begin
          acc_valid_i  = 1'b1;
          acc_result_i = acc_fn(win[0], win[1], win[2]);
        end
      end
      avm_waitrequest_i = (avm_write_o && force_wr_wait) ||
                          (int'($urandom_range(99)) < wait_pct);
      avm_readdata_i    = mem_word(avm_address_o);
      acc_data_ready_i  = (int'($urandom_range(99)) < ready_pct);
      // Handshakes that complete on the coming posedge.
      if (avm_read_o && !avm_waitrequest_i) rd_log.push_back(avm_address_o);
      if (avm_write_o && !avm_waitrequest_i) begin
        wa_log.push_back(avm_address_o);
        wd_log.push_back(avm_writedata_o);
      end
      if (acc_data_valid_o && acc_data_ready_i) begin
        push_log.push_back(acc_data_o);
        win[win_n] = acc_data_o;
        win_n++;
        last_push_cyc = cyc;
        if (win_n == NW) begin
          win_n = 0;
          if (!acc_silent) res_cd = (rand_lat ? int'($urandom_range(6)) : res_lat) + 1;
        end
      end
      prev_rd_stall   = avm_read_o && avm_waitrequest_i;
      prev_wr_stall   = avm_write_o && avm_waitrequest_i;
      prev_push_stall = acc_data_valid_o && !acc_data_ready_i;
      prev_addr       = avm_address_o;
      prev_wdata      = avm_writedata_o;
      prev_adata      = acc_data_o;
    end
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    clear_gen++;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic build_expected(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a;
    logic [31:0] w [NW];
    exp_rd.delete(); exp_push.delete(); exp_wa.delete(); exp_wd.delete();
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < int'(NW); k++) begin
        a = s + 32'(4 * (j * int'(NW) + k));
        w[k] = mem_word(a);
        exp_rd.push_back(a);
        exp_push.push_back(w[k]);
      end
      exp_wa.push_back(d + 32'(4 * j));
      exp_wd.push_back(acc_fn(w[0], w[1], w[2]));
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr_i = s; dst_addr_i = d; count_i = n; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; go_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; count_i = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy_o, done_o, error_o, avm_read_o, avm_write_o, acc_start_o,
         acc_data_valid_o, acc_result_ack_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000", {busy_o, done_o, error_o,
               avm_read_o, avm_write_o, acc_start_o, acc_data_valid_o, acc_result_ack_o});
    end
    n_tests++;
    if ({avm_address_o, avm_writedata_o, acc_data_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {avm_address_o, avm_writedata_o, acc_data_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_job();
    bit ok;
    clear_logs();
    wait_pct = 0; ready_pct = 100; rand_lat = 0; res_lat = 5; acc_silent = 0;
    seed_mem = $urandom;
    build_expected(32'h100, 32'h200, 1);
    launch(32'h100, 32'h200, 16'd1);
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy_o); end
    wait_done(200, ok);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_done: got no done want done"); end
    n_tests++;
    if (rd_log.size() != 3 || push_log.size() != 3 || wa_log.size() != 1) begin
      n_fail++;
      $display("FAIL single_counts: got rd=%0d push=%0d wr=%0d want 3/3/1",
               rd_log.size(), push_log.size(), wa_log.size());
    end
    for (int i = 0; i < 3 && i < rd_log.size() && i < push_log.size(); i++) begin
      n_tests++;
      if (rd_log[i] !== exp_rd[i] || push_log[i] !== exp_push[i]) begin
        n_fail++;
        $display("FAIL single_word%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, rd_log[i], push_log[i], exp_rd[i], exp_push[i]);
      end
    end
    if (wa_log.size() > 0) begin
      n_tests++;
      if (wa_log[0] !== 32'h200 || wd_log[0] !== exp_wd[0]) begin
        n_fail++;
        $display("FAIL single_write: got %h@%h want %h@200", wd_log[0], wa_log[0], exp_wd[0]);
      end
    end
    n_tests++;
    if (start_cnt != 1 || done_cnt != 1 || busy_o !== 1'b0 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: got start=%0d done=%0d busy=%b err=%b want 1 1 0 0",
               start_cnt, done_cnt, busy_o, error_o);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    wait_pct = 0; ready_pct = 100; rand_lat = 0; res_lat = 0;
    seed_mem = $urandom;
    build_expected(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2);
    launch(32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd2);
    wait_done(200, ok);
    n_tests++;
    if (!ok || done_cyc - first_start_cyc != 20) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles want 20", done_cyc - first_start_cyc);
    end
    n_tests++;
    if (rd_log != exp_rd || push_log != exp_push) begin
      n_fail++;
      $display("FAIL b2b_reads: got %0d reads (first %h) want %0d reads from fffffff8 wrapping",
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 32'hX, exp_rd.size());
    end
    n_tests++;
    if (wa_log != exp_wa || wd_log != exp_wd || start_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_writes: got %0d writes, %0d starts want 2 writes at fffffffc/0, 2 starts",
               wa_log.size(), start_cnt);
    end
  endtask

  task automatic test_multi_stall();
    bit ok;
    logic [31:0] s, d;
    clear_logs();
    wait_pct = 50; ready_pct = 50; rand_lat = 1;
    seed_mem = $urandom;
    s = $urandom & 32'hFFFF_FFFC;
    d = $urandom & 32'hFFFF_FFFC;
    build_expected(s, d, 3);
    launch(s, d, 16'd3);
    wait_done(3000, ok);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL multi_done: got no done want done"); end
    n_tests++;
    if (rd_log.size() != 9 || wa_log.size() != 3) begin
      n_fail++;
      $display("FAIL multi_counts: got rd=%0d wr=%0d want 9/3", rd_log.size(), wa_log.size());
    end
    for (int i = 0; i < rd_log.size() && i < push_log.size() && i < 9; i++) begin
      n_tests++;
      if (rd_log[i] !== exp_rd[i] || push_log[i] !== exp_push[i]) begin
        n_fail++;
        $display("FAIL multi_word%0d: got %h/%h want %h/%h", i, rd_log[i], push_log[i],
                 exp_rd[i], exp_push[i]);
      end
    end
    for (int i = 0; i < wa_log.size() && i < 3; i++) begin
      n_tests++;
      if (wa_log[i] !== exp_wa[i] || wd_log[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL multi_write%0d: got %h@%h want %h@%h", i, wd_log[i], wa_log[i],
                 exp_wd[i], exp_wa[i]);
      end
    end
    n_tests++;
    if (viol_cnt != 0 || start_cnt != 3 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL multi_protocol: got viol=%0d start=%0d done=%0d want 0 3 1",
               viol_cnt, start_cnt, done_cnt);
    end
    wait_pct = 0; ready_pct = 100; rand_lat = 0;
  endtask

  task automatic test_zero_count();
    clear_logs();
    @(negedge clk);
    src_addr_i = 32'h40; dst_addr_i = 32'h80; count_i = '0; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    n_tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b busy=%b want 1 0", done_o, busy_o);
    end
    @(negedge clk);
    n_tests++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got %b want 0", done_o); end
    repeat (5) @(posedge clk); #1;
    n_tests++;
    if (rd_log.size() + wa_log.size() + start_cnt != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_activity: got rd=%0d wr=%0d start=%0d done=%0d want 0 0 0 1",
               rd_log.size(), wa_log.size(), start_cnt, done_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    acc_silent = 1;
    launch(32'h1000, 32'h2000, 16'd2);
    wait_done(200, ok);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (!ok || error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_error: got done=%b error=%b want 1 1", ok, error_o);
    end
    n_tests++;
    if (done_cyc - last_push_cyc != 17) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d WAIT_RES cycles want 16", done_cyc - last_push_cyc - 1);
    end
    n_tests++;
    if (wa_log.size() != 0 || rd_log.size() != 3 || start_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_traffic: got wr=%0d rd=%0d start=%0d want 0 3 1",
               wa_log.size(), rd_log.size(), start_cnt);
    end
    clear_logs();
    acc_silent = 0; res_lat = 2;
    launch(32'h1000, 32'h2000, 16'd1);
    n_tests++;
    if (error_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", error_o); end
    wait_done(200, ok);
    n_tests++;
    if (!ok || error_o !== 1'b0 || wa_log.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_rerun: got done=%b err=%b wr=%0d want 1 0 1", ok, error_o, wa_log.size());
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen, ok;
    clear_logs();
    force_wr_wait = 1; res_lat = 1;
    launch(32'h300, 32'h400, 16'd1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_write_o) begin
        seen = 1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rstwr_reach: got no write want write"); end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    force_wr_wait = 0;
    n_tests++;
    if ({avm_write_o, avm_read_o, busy_o, done_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstwr_drop: got wr/rd/busy/done=%b want 0000",
               {avm_write_o, avm_read_o, busy_o, done_o});
    end
    repeat (6) @(posedge clk); #1;
    n_tests++;
    if (done_cnt != 0 || avm_write_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwr_idle: got done=%0d wr=%b busy=%b want 0 0 0",
               done_cnt, avm_write_o, busy_o);
    end
    clear_logs();
    launch(32'h300, 32'h400, 16'd1);
    wait_done(200, ok);
    n_tests++;
    if (!ok || wa_log.size() != 1) begin
      n_fail++;
      $display("FAIL rstwr_rerun: got done=%b wr=%0d want 1 1", ok, wa_log.size());
    end
  endtask

  task automatic test_go_while_busy();
    bit ok;
    clear_logs();
    res_lat = 3;
    seed_mem = $urandom;
    build_expected(32'h500, 32'h600, 2);
    launch(32'h500, 32'h600, 16'd2);
    repeat (4) @(negedge clk);
    src_addr_i = 32'h9000; dst_addr_i = 32'hA000; count_i = 16'd5; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    wait_done(300, ok);
    repeat (40) @(posedge clk); #1;
    n_tests++;
    if (!ok || done_cnt != 1 || start_cnt != 2) begin
      n_fail++;
      $display("FAIL busygo_count: got done=%0d start=%0d want 1 2", done_cnt, start_cnt);
    end
    n_tests++;
    if (rd_log != exp_rd || wa_log != exp_wa || wd_log != exp_wd) begin
      n_fail++;
      $display("FAIL busygo_traffic: got rd=%0d wr=%0d (first wr %h) want 6 2 at 600",
               rd_log.size(), wa_log.size(), (wa_log.size() > 0) ? wa_log[0] : 32'hX);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_multi_stall();
    test_zero_count();
    test_timeout();
    test_reset_mid_write();
    test_go_while_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
